// File: rtl/prbs_multi_gen.sv
// prbs_multi_gen: DATA_W-bit PRBS word generator for the D-PHY calibration/BIST path.
// Runtime polynomial select (PRBS-7/9/15/31), programmable seed, valid/ready output,
// finite bursts of Burst_Len words or continuous output when Burst_Len is zero.
// Optional feature: define PRBS_ERR_INJ_EN to add the Err_Inj port, which flips
// bit 0 of the next word loaded into Data.
module prbs_multi_gen #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              Clk,
  input  logic              TxRst,
  input  logic              Start,
  input  logic              Abort,
  input  logic [1:0]        Mode,
  input  logic [30:0]       Seed,
  input  logic              Seed_Load,
  input  logic [LEN_W-1:0]  Burst_Len,
`ifdef PRBS_ERR_INJ_EN
  input  logic              Err_Inj,
`endif
  output logic [DATA_W-1:0] Data,
  output logic              Valid,
  input  logic              Ready,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  state_t             next_state;
  logic [30:0]        lfsr;
  logic [30:0]        seed_reg;
  logic [30:0]        seed_eff;
  logic [1:0]         mode_lat;
  logic [LEN_W-1:0]   len_lat;
  logic [LEN_W-1:0]   count;
  logic [30:0]        gen_src;
  logic [1:0]         gen_mode;
  logic [30:0]        step_s;
  logic               fb;
  logic [DATA_W-1:0]  gen_word;
  logic [30:0]        gen_next;
  logic [DATA_W-1:0]  inj_mask;
  logic               start_ok;
  logic               accept;
  logic               last_word;
  logic               load_word;

  // Active-bit mask of the LFSR for each polynomial order
  function automatic logic [30:0] mode_mask(input logic [1:0] m);
    case (m)
      2'd0:    mode_mask = 31'h0000_007F;
      2'd1:    mode_mask = 31'h0000_01FF;
      2'd2:    mode_mask = 31'h0000_7FFF;
      default: mode_mask = 31'h7FFF_FFFF;
    endcase
  endfunction

  // Handshake and burst bookkeeping; a handshake cancelled by Abort is not a transfer
  always_comb begin
    start_ok  = (state == IDLE) && Start;
    accept    = (state == RUN) && Ready && !Abort;
    last_word = (len_lat != '0) && (count == len_lat);
    load_word = start_ok || (accept && !last_word);
  end

  // Seed actually used at Start: an all-zero seed would lock the LFSR, so use all-ones
  always_comb begin
    seed_eff = seed_reg & mode_mask(Mode);
    if (seed_eff == '0) begin
      seed_eff = mode_mask(Mode);
    end
  end

  // In IDLE the first word comes from the seed and the live Mode, in RUN from the LFSR
  always_comb begin
    gen_src  = (state == IDLE) ? seed_eff : lfsr;
    gen_mode = (state == IDLE) ? Mode : mode_lat;
  end

  // Unrolled DATA_W serial steps; bit i of the word is the i-th feedback bit produced
  always_comb begin
    step_s   = gen_src;
    gen_word = '0;
    fb       = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      case (gen_mode)
        2'd0:    fb = step_s[6]  ^ step_s[5];
        2'd1:    fb = step_s[8]  ^ step_s[4];
        2'd2:    fb = step_s[14] ^ step_s[13];
        default: fb = step_s[30] ^ step_s[27];
      endcase
      step_s      = {step_s[29:0], fb} & mode_mask(gen_mode);
      gen_word[i] = fb;
    end
    gen_next = step_s;
  end

`ifdef PRBS_ERR_INJ_EN
  logic err_pend;

  // Pending error flag: consumed by the next word load, dropped on Abort
  always_ff @(posedge Clk or posedge TxRst) begin
    if (TxRst) begin
      err_pend <= 1'b0;
    end else if ((state == RUN) && Abort) begin
      err_pend <= 1'b0;
    end else if (load_word) begin
      err_pend <= Err_Inj;
    end else if (Err_Inj) begin
      err_pend <= 1'b1;
    end
  end

  // Corruption touches only bit 0 of the loaded word, never the LFSR itself
  always_comb begin
    inj_mask    = '0;
    inj_mask[0] = err_pend;
  end
`else
  assign inj_mask = '0;
`endif

  // FSM state register
  always_ff @(posedge Clk or posedge TxRst) begin
    if (TxRst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: Abort beats a handshake, the final handshake of a finite burst ends it
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Start) next_state = RUN;
      RUN:     if (Abort || (Ready && last_word)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: Valid mirrors RUN, Busy also covers the Done cycle
  always_comb begin
    Valid = (state == RUN);
    Busy  = (state == RUN) || Done;
  end

  // Done pulses for one cycle whenever a burst leaves RUN
  always_ff @(posedge Clk or posedge TxRst) begin
    if (TxRst) begin
      Done <= 1'b0;
    end else begin
      Done <= (state == RUN) && (next_state == IDLE);
    end
  end

  // Seed register is writable at any time and only matters at the next Start
  always_ff @(posedge Clk or posedge TxRst) begin
    if (TxRst) begin
      seed_reg <= '1;
    end else if (Seed_Load) begin
      seed_reg <= Seed;
    end
  end

  // Datapath: sample Mode/Burst_Len at Start, then advance only on accepted handshakes
  always_ff @(posedge Clk or posedge TxRst) begin
    if (TxRst) begin
      Data     <= '0;
      lfsr     <= '0;
      count    <= '0;
      mode_lat <= '0;
      len_lat  <= '0;
    end else begin
      if (start_ok) begin
        mode_lat <= Mode;
        len_lat  <= Burst_Len;
        count    <= LEN_W'(1);
      end else if (accept && !last_word) begin
        count    <= count + LEN_W'(1);
      end
      if (load_word) begin
        Data <= gen_word ^ inj_mask;
        lfsr <= gen_next;
      end
    end
  end

endmodule

// File: tb/tb_prbs_multi_gen.sv
// tb_prbs_multi_gen: scoreboard bench for prbs_multi_gen (DATA_W=8, LEN_W=16).
// Stimulus pushes expected words from a bit-serial reference into a queue; the
// monitor pops and compares on every accepted handshake.
module tb_prbs_multi_gen;

  logic        Clk = 1'b0;
  logic        TxRst;
  logic        Start;
  logic        Abort;
  logic [1:0]  Mode;
  logic [30:0] Seed;
  logic        Seed_Load;
  logic [15:0] Burst_Len;
  logic [7:0]  Data;
  logic        Valid;
  logic        Ready;
  logic        Busy;
  logic        Done;
`ifdef PRBS_ERR_INJ_EN
  logic        Err_Inj;
`endif

  int          errors  = 0;
  int          checks  = 0;
  int          rxCount = 0;
  logic [7:0]  expQ[$];
  logic [7:0]  rxLog[$];
  logic [30:0] mS;
  logic [30:0] mMask;
  int          mN;
  int          mT;
  bit          holdValid = 1'b0;
  logic [7:0]  holdData;

  prbs_multi_gen #(.DATA_W(8), .LEN_W(16)) dut (
    .Clk       (Clk),
    .TxRst     (TxRst),
    .Start     (Start),
    .Abort     (Abort),
    .Mode      (Mode),
    .Seed      (Seed),
    .Seed_Load (Seed_Load),
    .Burst_Len (Burst_Len),
`ifdef PRBS_ERR_INJ_EN
    .Err_Inj   (Err_Inj),
`endif
    .Data      (Data),
    .Valid     (Valid),
    .Ready     (Ready),
    .Busy      (Busy),
    .Done      (Done)
  );

  // Free-running clock
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Bit-serial reference: load with the all-zero substitution rule
  task automatic modelLoad(input logic [1:0] mode, input logic [30:0] seed);
    case (mode)
      2'd0:    begin mN = 7;  mT = 6;  mMask = 31'h0000_007F; end
      2'd1:    begin mN = 9;  mT = 5;  mMask = 31'h0000_01FF; end
      2'd2:    begin mN = 15; mT = 14; mMask = 31'h0000_7FFF; end
      default: begin mN = 31; mT = 28; mMask = 31'h7FFF_FFFF; end
    endcase
    mS = seed & mMask;
    if (mS == '0) mS = mMask;
  endtask

  task automatic modelWord(output logic [7:0] w);
    logic f;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      f    = mS[mN-1] ^ mS[mT-1];
      mS   = ((mS << 1) | {30'b0, f}) & mMask;
      w[i] = f;
    end
  endtask

  task automatic pushWords(input int n, input int flipIdx);
    logic [7:0] w;
    for (int k = 0; k < n; k++) begin
      modelWord(w);
      if (k == flipIdx) w[0] = ~w[0];
      expQ.push_back(w);
    end
  endtask

  // Pulse Start for one edge; returns just after that edge
  task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] len);
    Mode      = mode;
    Burst_Len = len;
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
  endtask

  task automatic waitRx(input int target, input int budget, input string name);
    int c = 0;
    while (rxCount < target && c < budget) begin
      tick();
      c++;
    end
    checkOutput(name, rxCount, target);
  endtask

  task automatic waitDone(input int budget, output int vcnt, output bit got);
    vcnt = 0;
    got  = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (Valid) vcnt++;
      if (Done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Monitor: stability while stalled, and scoreboard pop on each real handshake
  always @(negedge Clk) begin
    if (TxRst) begin
      holdValid = 1'b0;
    end else begin
      if (holdValid && Valid) checkOutput("hold_stable", Data, holdData);
      if (Valid && Ready && !Abort) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word actual=0x%0h required=none", Data);
        end else begin
          checkOutput("word", Data, expQ.pop_front());
        end
        rxLog.push_back(Data);
        rxCount++;
      end
      holdValid = Valid && !Ready && !Abort;
      holdData  = Data;
    end
  end

  // Global time limit so the bench always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  base;
    int  v;
    bit  g;
    logic [31:0] pat;
    int  ks[5];

    TxRst = 1'b1; Start = 1'b0; Abort = 1'b0; Seed_Load = 1'b0; Ready = 1'b0;
    Mode = 2'd0; Seed = '0; Burst_Len = '0;
`ifdef PRBS_ERR_INJ_EN
    Err_Inj = 1'b0;
`endif
    repeat (3) tick();
    checkOutput("rst_data", Data, 0);
    checkOutput("rst_valid", Valid, 0);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done", Done, 0);
    TxRst = 1'b0;
    tick();

    // PRBS-9 burst of 4 from the reset seed
    $display("[TB] PRBS-9 burst");
    Ready = 1'b1;
    modelLoad(2'd1, 31'h7FFF_FFFF);
    pushWords(4, -1);
    base = rxCount;
    applyStimulus(2'd1, 16'd4);
    checkOutput("prbs9_first_word", Data, 8'hE0);
    checkOutput("prbs9_valid_after_start", Valid, 1);
    checkOutput("prbs9_busy_after_start", Busy, 1);
    waitDone(20, v, g);
    checkOutput("prbs9_valid_cycles", v, 4);
    checkOutput("prbs9_done_seen", g, 1);
    checkOutput("prbs9_busy_with_done", Busy, 1);
    checkOutput("prbs9_valid_with_done", Valid, 0);
    checkOutput("prbs9_handshakes", rxCount - base, 4);
    tick();
    checkOutput("prbs9_done_one_cycle", Done, 0);
    checkOutput("prbs9_busy_drop", Busy, 0);
    checkOutput("prbs9_queue_empty", expQ.size(), 0);

    // PRBS-7 continuous, period check, then Abort
    $display("[TB] PRBS-7 continuous");
    rxLog.delete();
    modelLoad(2'd0, 31'h7FFF_FFFF);
    pushWords(260, -1);
    base = rxCount;
    applyStimulus(2'd0, 16'd0);
    checkOutput("prbs7_first_word", Data, 8'h40);
    waitRx(base + 260, 400, "prbs7_handshakes");
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    checkOutput("prbs7_abort_done", Done, 1);
    checkOutput("prbs7_abort_valid", Valid, 0);
    ks = '{0, 1, 2, 60, 132};
    if (rxLog.size() >= 260) begin
      foreach (ks[j]) checkOutput($sformatf("prbs7_period_k%0d", ks[j]), rxLog[ks[j] + 127], rxLog[ks[j]]);
    end
    checkOutput("prbs7_queue_empty", expQ.size(), 0);
    tick();

    // Backpressure with a fixed Ready pattern and a loaded non-zero seed
    $display("[TB] backpressure");
    Seed = 31'h1234_5678;
    Seed_Load = 1'b1;
    tick();
    Seed_Load = 1'b0;
    modelLoad(2'd1, 31'h1234_5678);
    pushWords(10, -1);
    pat = 32'b1011_0010_0110_1101_0011_1000_1110_0101;
    Ready = 1'b0;
    base = rxCount;
    applyStimulus(2'd1, 16'd10);
    for (int c = 0; c < 100 && !Done; c++) begin
      Ready = pat[c % 32];
      tick();
    end
    checkOutput("bp_done", Done, 1);
    checkOutput("bp_handshakes", rxCount - base, 10);
    checkOutput("bp_queue_empty", expQ.size(), 0);
    Ready = 1'b1;
    tick();

    // Abort coincident with the handshake of word 3 of 8
    $display("[TB] abort");
    modelLoad(2'd1, 31'h1234_5678);
    pushWords(2, -1);
    base = rxCount;
    applyStimulus(2'd1, 16'd8);
    waitRx(base + 2, 20, "abort_pre_handshakes");
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    checkOutput("abort_done", Done, 1);
    checkOutput("abort_valid", Valid, 0);
    checkOutput("abort_busy_with_done", Busy, 1);
    checkOutput("abort_transferred", rxCount - base, 2);
    tick();
    checkOutput("abort_busy_drop", Busy, 0);
    checkOutput("abort_done_drop", Done, 0);
    checkOutput("abort_queue_empty", expQ.size(), 0);

    // Zero seed on PRBS-15, and a Start during RUN that must be ignored
    $display("[TB] zero seed");
    Seed = '0;
    Seed_Load = 1'b1;
    tick();
    Seed_Load = 1'b0;
    modelLoad(2'd2, 31'h0);
    pushWords(3, -1);
    Ready = 1'b0;
    base = rxCount;
    applyStimulus(2'd2, 16'd3);
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    checkOutput("start_in_run_valid", Valid, 1);
    Ready = 1'b1;
    waitDone(20, v, g);
    checkOutput("zs_done_seen", g, 1);
    checkOutput("zs_handshakes", rxCount - base, 3);
    checkOutput("zs_queue_empty", expQ.size(), 0);
    tick();

    // Reset mid-burst, then PRBS-31 with Mode/Burst_Len changed during RUN
    $display("[TB] reset mid-burst");
    modelLoad(2'd1, 31'h0);
    pushWords(3, -1);
    base = rxCount;
    applyStimulus(2'd1, 16'd0);
    waitRx(base + 3, 20, "rst_pre_handshakes");
    TxRst = 1'b1;
    #1;
    checkOutput("midrst_data", Data, 0);
    checkOutput("midrst_valid", Valid, 0);
    checkOutput("midrst_busy", Busy, 0);
    checkOutput("midrst_done", Done, 0);
    tick();
    TxRst = 1'b0;
    tick();
    checkOutput("midrst_no_done", Done, 0);
    checkOutput("midrst_queue_empty", expQ.size(), 0);
    modelLoad(2'd3, 31'h7FFF_FFFF);
    pushWords(6, -1);
    base = rxCount;
    applyStimulus(2'd3, 16'd6);
    Mode = 2'd0;
    Burst_Len = 16'd2;
    waitDone(30, v, g);
    checkOutput("prbs31_done_seen", g, 1);
    checkOutput("prbs31_valid_cycles", v, 6);
    checkOutput("prbs31_handshakes", rxCount - base, 6);
    checkOutput("prbs31_queue_empty", expQ.size(), 0);
    tick();

`ifdef PRBS_ERR_INJ_EN
    // Error injection while word 2 is stalled corrupts bit 0 of word 3 only
    $display("[TB] error injection");
    modelLoad(2'd1, 31'h7FFF_FFFF);
    pushWords(5, 2);
    base = rxCount;
    applyStimulus(2'd1, 16'd5);
    waitRx(base + 1, 20, "inj_pre_handshakes");
    Ready = 1'b0;
    Err_Inj = 1'b1;
    tick();
    Err_Inj = 1'b0;
    Ready = 1'b1;
    waitDone(30, v, g);
    checkOutput("inj_done_seen", g, 1);
    checkOutput("inj_handshakes", rxCount - base, 5);
    checkOutput("inj_queue_empty", expQ.size(), 0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
